// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, freeze and a
// saturating back-pressure counter.
// Optional macro PIPE_STAGE_REG_SKID_EN adds a second (skid) entry so that
// in_ready is a registered signal. Without it, the stage holds one word and
// in_ready is combinational.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              freeze,
  input  logic              stall_clr,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam logic [1:0] StTwo   = 2'd2;
`endif
  localparam logic [15:0] StallMax = 16'hFFFF;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              rdy_q, rdy_d;
  logic [15:0]       stall_q, stall_d;
  logic              in_fire, out_fire;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
`endif

  assign out_valid = (state_q != StEmpty);
  assign out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign out_data  = head_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  // Ready: rdy_q is low throughout reset and rises on the first edge after it.
`ifdef PIPE_STAGE_REG_SKID_EN
  assign in_ready = rdy_q & ~freeze & ~flush;
`else
  assign in_ready = rdy_q & (~out_valid | out_ready) & ~freeze & ~flush;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~freeze & ~flush;

  // Occupancy FSM and payload movement.
  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
`ifdef PIPE_STAGE_REG_SKID_EN
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
`endif
    if (flush) begin
      // Data bits are left alone; only control is scrubbed.
      state_d     = StEmpty;
      head_ctrl_d = '0;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_ctrl_d = '0;
`endif
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d     = StOne;
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
`ifdef PIPE_STAGE_REG_SKID_EN
          end else if (in_fire) begin
            state_d     = StTwo;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
`else
          end else if (in_fire) begin
            // Unreachable: in_ready requires out_ready when holding a word.
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
`endif
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        StTwo: begin
          if (out_fire) begin
            state_d     = StOne;
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
          end
        end
`endif
        default: state_d = StEmpty;
      endcase
    end
  end

  // Registered ready tracks whether the next state still has room.
  always_comb begin
`ifdef PIPE_STAGE_REG_SKID_EN
    rdy_d = (state_d != StTwo);
`else
    rdy_d = 1'b1;
`endif
  end

  // Saturating back-pressure counter; freeze holds it, clear beats increment.
  always_comb begin
    stall_d = stall_q;
    if (!freeze) begin
      if (stall_clr) begin
        stall_d = '0;
      end else if (out_valid && !out_ready && (stall_q != StallMax)) begin
        stall_d = stall_q + 16'd1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StEmpty;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      rdy_q       <= 1'b0;
      stall_q     <= '0;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      rdy_q       <= rdy_d;
      stall_q     <= stall_d;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; works with or without
// PIPE_STAGE_REG_SKID_EN defined.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int NWORDS = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              freeze;
  logic              stall_clr;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .flush    (flush),
    .freeze   (freeze),
    .stall_clr(stall_clr),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00AA; in_data = 32'hDEAD_BEEF;
    out_ready = 1'b0; flush = 1'b0; freeze = 1'b0; stall_clr = 1'b0;
    repeat (3) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_ctrl !== 16'h0) begin n_err++; $display("FAIL rst_out_ctrl got %h want 0", out_ctrl); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL rst_stall_cnt got %h want 0", stall_cnt); end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_valid got %b want 0", out_valid); end
  endtask

  task automatic test_single;
    in_valid = 1'b1; in_data = 32'h0000_1234; in_ctrl = 16'h0005; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h0000_1234) begin n_err++; $display("FAIL single_data got %h want 00001234", out_data); end
    n_cmp++; if (out_ctrl !== 16'h0005) begin n_err++; $display("FAIL single_ctrl got %h want 0005", out_ctrl); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 16'h0) begin n_err++; $display("FAIL single_ctrl_zero got %h want 0", out_ctrl); end
  endtask

  task automatic test_skid;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'h0001; in_data = 32'h11;
    tick();
    in_ctrl = 16'h0002; in_data = 32'h22;
`ifdef PIPE_STAGE_REG_SKID_EN
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_one got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL skid_occ2 got %0d want 2", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_full got %b want 0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_data !== 32'h11 || out_valid !== 1'b1) begin n_err++; $display("FAIL skid_first got %h want 11", out_data); end
    tick();
    n_cmp++; if (out_data !== 32'h22 || out_valid !== 1'b1) begin n_err++; $display("FAIL skid_second got %h want 22", out_data); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL skid_occ1 got %0d want 1", occupancy); end
    tick();
`else
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL noskid_ready_full got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL noskid_occ got %0d want 1", occupancy); end
    tick();
    n_cmp++; if (out_data !== 32'h11) begin n_err++; $display("FAIL noskid_hold got %h want 11", out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
`endif
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL skid_drained got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0003; in_data = 32'h33;
    tick();
`ifdef PIPE_STAGE_REG_SKID_EN
    in_ctrl = 16'h0004; in_data = 32'h44;
    tick();
`endif
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0009; in_data = 32'h99; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 16'h0) begin n_err++; $display("FAIL flush_ctrl got %h want 0", out_ctrl); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost got %b want 0", out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_freeze;
    stall_clr = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0007; in_data = 32'hCAFE_0007; out_ready = 1'b0;
    tick();
    stall_clr = 1'b0; in_valid = 1'b0;
    tick();
    freeze = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL freeze_ready got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hCAFE_0007) begin n_err++; $display("FAIL freeze_data got %h want cafe0007", out_data); end
      n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL freeze_stall got %0d want 1", stall_cnt); end
      tick();
    end
    freeze = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL freeze_release got %b want 0", out_valid); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL freeze_stall_after got %0d want 1", stall_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall_sat;
    stall_clr = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0008; in_data = 32'h88; out_ready = 1'b0;
    tick();
    stall_clr = 1'b0; in_valid = 1'b0;
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stall_start got %0d want 0", stall_cnt); end
    for (int n = 1; n <= 65600; n++) begin
      tick();
      if (n == 100) begin
        n_cmp++; if (stall_cnt !== 16'd100) begin n_err++; $display("FAIL stall_100 got %0d want 100", stall_cnt); end
      end
    end
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL stall_sat got %h want ffff", stall_cnt); end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stall_clr got %h want 0", stall_cnt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [CTRL_W+DATA_W-1:0] q[$];
    logic exp_rdy;
    int sent = 0;
    int got = 0;
    int cycles = 0;
    while (got < NWORDS && cycles < 40000) begin
      in_valid  = (sent < NWORDS) && ($urandom_range(0, 3) != 0);
      in_ctrl   = CTRL_W'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
`ifdef PIPE_STAGE_REG_SKID_EN
      exp_rdy = (q.size() < 2);
`else
      exp_rdy = (q.size() == 0) || out_ready;
      n_cmp++; if (occupancy > 2'd1) begin n_err++; $display("FAIL rnd_occ_max got %0d want <=1", occupancy); end
`endif
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; if (n_err < 20) $display("FAIL rnd_ready got %b want %b", in_ready, exp_rdy); end
      n_cmp++; if (out_valid !== (q.size() != 0)) begin n_err++; if (n_err < 20) $display("FAIL rnd_valid got %b want %b", out_valid, q.size() != 0); end
      n_cmp++; if (occupancy !== 2'(q.size())) begin n_err++; if (n_err < 20) $display("FAIL rnd_occ got %0d want %0d", occupancy, q.size()); end
      if (out_valid && out_ready && q.size() != 0) begin
        n_cmp++;
        if ({out_ctrl, out_data} !== q[0]) begin
          n_err++; if (n_err < 20) $display("FAIL rnd_word got %h want %h", {out_ctrl, out_data}, q[0]);
        end
        void'(q.pop_front());
        got++;
      end else if (!out_valid) begin
        n_cmp++; if (out_ctrl !== '0) begin n_err++; if (n_err < 20) $display("FAIL rnd_ctrl_zero got %h want 0", out_ctrl); end
      end
      if (in_valid && in_ready) begin
        q.push_back({in_ctrl, in_data});
        sent++;
      end
      tick();
      cycles++;
    end
    n_cmp++;
    if (got < NWORDS) begin n_err++; $display("FAIL rnd_timeout got %0d want %0d words", got, NWORDS); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_skid();
    test_flush();
    test_freeze();
    test_stall_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
